// File: rtl/raygen_pkg.sv
// raygen_pkg: shared types and constants for the pixel ray generator.
// vec3_t carries the default 16-bit component width; modules whose
// POSITION_WIDTH is overridden declare their own [2:0][POSITION_WIDTH-1:0]
// arrays with the same layout ([0]=x, [1]=y, [2]=z).
package raygen_pkg;

  // Width of pixel coordinates and frame dimensions.
  localparam int PIXEL_W = 12;

  // Default component width of a 3-vector.
  localparam int POS_W_DEFAULT = 16;

  typedef logic [2:0][POS_W_DEFAULT-1:0] vec3_t;

  // Generator FSM states; the top maps these onto plain 2-bit constants.
  typedef enum logic [1:0] {
    RG_IDLE  = 2'd0,
    RG_EMIT  = 2'd1,
    RG_DRAIN = 2'd2
  } raygen_state_e;

endpackage

// File: rtl/pixel_ray_generator_if.sv
// pixel_ray_generator_if: ray output channel plus the retire return path.
//
// Handshake: the master raises rayValid with a stable payload (rayOrigin,
// rayDir, pixelX, pixelY, rayLast); a transfer happens on every rising clock
// edge where rayValid && rayReady. While rayValid && !rayReady the payload
// holds and rayValid stays high (only flush or reset may withdraw it).
// rayReady may depend on nothing from the master. rayRetired is an
// independent one-cycle pulse from the slave for each ray it has finished.
interface pixel_ray_generator_if #(
  parameter int POSITION_WIDTH = 16
) ();
  import raygen_pkg::*;

  logic                           rayValid;
  logic                           rayReady;
  logic [2:0][POSITION_WIDTH-1:0] rayOrigin;
  logic [2:0][POSITION_WIDTH-1:0] rayDir;
  logic [PIXEL_W-1:0]             pixelX;
  logic [PIXEL_W-1:0]             pixelY;
  logic                           rayLast;
  logic                           rayRetired;

  modport master (
    output rayValid, rayOrigin, rayDir, pixelX, pixelY, rayLast,
    input  rayReady, rayRetired
  );

  modport slave (
    input  rayValid, rayOrigin, rayDir, pixelX, pixelY, rayLast,
    output rayReady, rayRetired
  );

endinterface

// File: rtl/vec3_add.sv
// vec3_add: component-wise 3-vector adder; each component wraps modulo
// 2^POSITION_WIDTH (no saturation, carries never cross components).
module vec3_add #(
  parameter int POSITION_WIDTH = 16
) (
  input  logic [2:0][POSITION_WIDTH-1:0] a,
  input  logic [2:0][POSITION_WIDTH-1:0] b,
  output logic [2:0][POSITION_WIDTH-1:0] sum
);

  // Independent wrapping add per component.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = a[i] + b[i];
    end
  end

endmodule

// File: rtl/pixel_ray_generator.sv
// pixel_ray_generator: walks the configured frame in raster order and emits
// one primary ray per pixel. Directions are built incrementally: the column
// step adds X to the current direction, the row step adds Y to a row
// accumulator that holds the direction of the first pixel of the row.
// All camera vectors and frame dimensions are latched on an accepted start.
// Rays in flight downstream are counted and capped at MAX_OUTSTANDING; the
// block stays busy until every issued ray has been retired.
//
// Optional feature macro: RAYGEN_PERF_EN -- when defined, frameCycles reports
// the number of non-idle cycles of the most recently completed frame;
// otherwise frameCycles is constant 0.
module pixel_ray_generator
  import raygen_pkg::*;
#(
  parameter int POSITION_WIDTH  = 16,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CYCLE_WIDTH     = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraQ,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraV,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraX,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraY,
  input  logic [PIXEL_W-1:0]             width,
  input  logic [PIXEL_W-1:0]             height,
  input  logic                           start,
  input  logic                           flush,
  output logic                           ready,
  output logic                           busy,
  output logic [CYCLE_WIDTH-1:0]         frameCycles,
  output logic [1:0]                     stateDebug,
  pixel_ray_generator_if.master          ray
);

  localparam logic [1:0] S_IDLE  = RG_IDLE;
  localparam logic [1:0] S_EMIT  = RG_EMIT;
  localparam logic [1:0] S_DRAIN = RG_DRAIN;

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  localparam int              CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(MAX_OUTSTANDING);

  logic [1:0]                     state;
  logic [CNT_W-1:0]               outCnt;
  logic [CNT_W-1:0]               cntNext;

  logic [2:0][POSITION_WIDTH-1:0] qLat;
  logic [2:0][POSITION_WIDTH-1:0] xLat;
  logic [2:0][POSITION_WIDTH-1:0] yLat;
  logic [2:0][POSITION_WIDTH-1:0] rowAcc;
  logic [2:0][POSITION_WIDTH-1:0] dirReg;
  logic [2:0][POSITION_WIDTH-1:0] colSum;
  logic [2:0][POSITION_WIDTH-1:0] rowSum;
  logic [PIXEL_W-1:0]             wLat;
  logic [PIXEL_W-1:0]             hLat;
  logic [PIXEL_W-1:0]             pxReg;
  logic [PIXEL_W-1:0]             pyReg;

  logic startOk;
  logic atCap;
  logic handshake;
  logic retireEff;
  logic endOfRow;
  logic lastPix;

  // Column step: next direction along the current row.
  vec3_add #(.POSITION_WIDTH(POSITION_WIDTH)) u_col_add (
    .a   (dirReg),
    .b   (xLat),
    .sum (colSum)
  );

  // Row step: direction of the first pixel of the next row.
  vec3_add #(.POSITION_WIDTH(POSITION_WIDTH)) u_row_add (
    .a   (rowAcc),
    .b   (yLat),
    .sum (rowSum)
  );

  // Handshake, retire qualification and next outstanding count.
  always_comb begin
    startOk   = start && (width != '0) && (height != '0);
    atCap     = (outCnt == CAP);
    handshake = ray.rayValid && ray.rayReady;
    // A retire with nothing outstanding cannot correspond to a real ray.
    retireEff = ray.rayRetired && (outCnt != '0);
    endOfRow  = (pxReg == wLat - PIXEL_W'(1));
    lastPix   = endOfRow && (pyReg == hLat - PIXEL_W'(1));
    cntNext   = outCnt;
    if (handshake && !retireEff) begin
      cntNext = outCnt + CNT_W'(1);
    end else if (!handshake && retireEff) begin
      cntNext = outCnt - CNT_W'(1);
    end
  end

  // Frame sequencing: IDLE -> EMIT on a usable start, EMIT -> DRAIN on the
  // last handshake or flush, DRAIN -> IDLE once nothing remains outstanding.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (startOk) begin
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (flush || (handshake && lastPix)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cntNext == '0) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Rays issued but not yet retired downstream.
  always_ff @(posedge clock) begin
    if (!reset) begin
      outCnt <= '0;
    end else begin
      outCnt <= cntNext;
    end
  end

  // Frame setup on start, then raster walk of pixel and direction on each
  // accepted ray. Nothing moves while the current ray is waiting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      qLat   <= '0;
      xLat   <= '0;
      yLat   <= '0;
      rowAcc <= '0;
      dirReg <= '0;
      wLat   <= '0;
      hLat   <= '0;
      pxReg  <= '0;
      pyReg  <= '0;
    end else if ((state == S_IDLE) && startOk) begin
      qLat   <= cameraQ;
      xLat   <= cameraX;
      yLat   <= cameraY;
      rowAcc <= cameraV;
      dirReg <= cameraV;
      wLat   <= width;
      hLat   <= height;
      pxReg  <= '0;
      pyReg  <= '0;
    end else if (handshake) begin
      if (!endOfRow) begin
        pxReg  <= pxReg + PIXEL_W'(1);
        dirReg <= colSum;
      end else begin
        pxReg  <= '0;
        pyReg  <= pyReg + PIXEL_W'(1);
        rowAcc <= rowSum;
        dirReg <= rowSum;
      end
    end
  end

  // Valid is withheld only at the outstanding cap; the cap is reached only
  // through a handshake, so a pending ray is never withdrawn by it.
  assign ray.rayValid  = (state == S_EMIT) && !atCap;
  assign ray.rayOrigin = qLat;
  assign ray.rayDir    = dirReg;
  assign ray.pixelX    = pxReg;
  assign ray.pixelY    = pyReg;
  assign ray.rayLast   = lastPix;

  assign ready      = (state == S_IDLE);
  assign busy       = !ready;
  assign stateDebug = state;

`ifdef RAYGEN_PERF_EN
  logic [CYCLE_WIDTH-1:0] cycCnt;
  logic [CYCLE_WIDTH-1:0] frameReg;

  // Count non-idle cycles of the current frame; publish the total (including
  // the final drain cycle) as the frame returns to idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycCnt   <= '0;
      frameReg <= '0;
    end else if (state == S_IDLE) begin
      if (startOk) begin
        cycCnt <= '0;
      end
    end else begin
      cycCnt <= cycCnt + CYCLE_WIDTH'(1);
      if ((state == S_DRAIN) && (cntNext == '0)) begin
        frameReg <= cycCnt + CYCLE_WIDTH'(1);
      end
    end
  end

  assign frameCycles = frameReg;
`else
  assign frameCycles = '0;
`endif

endmodule

// File: tb/tb_pixel_ray_generator.sv
// tb_pixel_ray_generator: directed scenarios plus randomized frames against a
// reference model that lists each frame's rays up front (direction computed
// as V + x*X + y*Y) and tracks in-flight rays as a plain count.
module tb_pixel_ray_generator;
  import raygen_pkg::*;

  localparam int PW   = 16;
  localparam int MAXO = 4;
  localparam int CW   = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  vec3_t              cameraQ, cameraV, cameraX, cameraY;
  logic [PIXEL_W-1:0] width, height;
  logic               start, flush;
  logic               ready, busy;
  logic [CW-1:0]      frameCycles;
  logic [1:0]         stateDebug;

  pixel_ray_generator_if #(.POSITION_WIDTH(PW)) rif ();

  pixel_ray_generator #(
    .POSITION_WIDTH  (PW),
    .MAX_OUTSTANDING (MAXO),
    .CYCLE_WIDTH     (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cameraQ     (cameraQ),
    .cameraV     (cameraV),
    .cameraX     (cameraX),
    .cameraY     (cameraY),
    .width       (width),
    .height      (height),
    .start       (start),
    .flush       (flush),
    .ready       (ready),
    .busy        (busy),
    .frameCycles (frameCycles),
    .stateDebug  (stateDebug),
    .ray         (rif.master)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [PIXEL_W-1:0] x;
    logic [PIXEL_W-1:0] y;
    vec3_t              dir;
    logic               last;
  } ray_t;

  ray_t          exp_q[$];
  int            m_out;
  bit            m_busy;
  bit            m_emit;
  vec3_t         m_q;
  logic [CW-1:0] m_cyc;
  logic [CW-1:0] m_frame;
  int            hs_cnt;
  int            compared;
  int            mismatched;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected rays of a frame in raster order, from the current inputs.
  task automatic build_frame(input int w, input int h);
    ray_t r;
    exp_q.delete();
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        r.x = PIXEL_W'(xx);
        r.y = PIXEL_W'(yy);
        for (int c = 0; c < 3; c++) begin
          r.dir[c] = cameraV[c] + cameraX[c] * PW'(xx) + cameraY[c] * PW'(yy);
        end
        r.last = (xx == w - 1) && (yy == h - 1);
        exp_q.push_back(r);
      end
    end
  endtask

  function automatic bit exp_valid();
    return m_emit && (m_out < MAXO);
  endfunction

  // One clock: advance the model on the edge, then check outputs mid-cycle.
  task automatic tick();
    bit   hs;
    bit   ret_eff;
    bit   was_emit;
    bit   was_busy;
    ray_t r;
    r  = '0;
    hs = exp_valid() && rif.rayReady;
    @(posedge clock);
    if (!reset) begin
      exp_q.delete();
      m_out   = 0;
      m_busy  = 0;
      m_emit  = 0;
      m_cyc   = '0;
      m_frame = '0;
    end else begin
      ret_eff  = rif.rayRetired && (m_out > 0);
      was_emit = m_emit;
      was_busy = m_busy;
      if (was_busy) m_cyc++;
      if (hs) begin
        r = exp_q.pop_front();
        hs_cnt++;
      end
      m_out = m_out + int'(hs) - int'(ret_eff);
      if (was_emit) begin
        if (flush || (hs && r.last)) begin
          m_emit = 0;
          exp_q.delete();
        end
      end else if (was_busy) begin
        if (m_out == 0) begin
          m_busy  = 0;
          m_frame = m_cyc;
        end
      end else if (start && (width != 0) && (height != 0)) begin
        build_frame(int'(width), int'(height));
        m_q    = cameraQ;
        m_busy = 1;
        m_emit = 1;
        m_cyc  = '0;
      end
    end
    @(negedge clock);
    check_val("ready", 64'(ready), 64'(!m_busy));
    check_val("busy", 64'(busy), 64'(m_busy));
    check_val("rayValid", 64'(rif.rayValid), 64'(exp_valid()));
    if (exp_valid() && exp_q.size() > 0) begin
      check_val("pixelX", 64'(rif.pixelX), 64'(exp_q[0].x));
      check_val("pixelY", 64'(rif.pixelY), 64'(exp_q[0].y));
      check_val("rayDir", 64'(rif.rayDir), 64'(exp_q[0].dir));
      check_val("rayOrigin", 64'(rif.rayOrigin), 64'(m_q));
      check_val("rayLast", 64'(rif.rayLast), 64'(exp_q[0].last));
    end
`ifdef RAYGEN_PERF_EN
    check_val("frameCycles", 64'(frameCycles), 64'(m_frame));
`else
    check_val("frameCycles", 64'(frameCycles), 64'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start          = 1'b0;
    flush          = 1'b0;
    rif.rayReady   = 1'b1;
    rif.rayRetired = 1'b0;
  endtask

  task automatic random_camera();
    for (int c = 0; c < 3; c++) begin
      cameraQ[c] = PW'($urandom);
      cameraV[c] = PW'($urandom);
      cameraX[c] = PW'($urandom);
      cameraY[c] = PW'($urandom);
    end
  endtask

  task automatic start_frame(input int w, input int h);
    width  = PIXEL_W'(w);
    height = PIXEL_W'(h);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Run until the model goes idle, retiring rays; bounded by a cycle budget.
  task automatic run_to_idle(input int budget, input bit random_mode);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      if (random_mode) begin
        rif.rayReady   = ($urandom_range(0, 3) != 0);
        rif.rayRetired = (m_out > 0) && ($urandom_range(0, 2) == 0);
        flush          = m_emit && ($urandom_range(0, 40) == 0);
        start          = ($urandom_range(0, 5) == 0);
        random_camera();
        width          = PIXEL_W'($urandom_range(0, 7));
        height         = PIXEL_W'($urandom_range(0, 7));
      end else begin
        rif.rayReady   = 1'b1;
        rif.rayRetired = (m_out > 0);
      end
      tick();
      n++;
    end
    idle_inputs();
    check_val("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    compared   = 0;
    mismatched = 0;
    hs_cnt     = 0;
    m_out      = 0;
    m_busy     = 0;
    m_emit     = 0;
    m_cyc      = '0;
    m_frame    = '0;
    m_q        = '0;
    random_camera();
    width  = '0;
    height = '0;
    idle_inputs();

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_val("rst_rayDir", 64'(rif.rayDir), 64'd0);
    check_val("rst_pixelX", 64'(rif.pixelX), 64'd0);
    check_val("rst_origin", 64'(rif.rayOrigin), 64'd0);

    // 2x2 frame, full throughput, retires held back
    cameraV = '0; cameraV[2] = 16'h0100;
    cameraX = '0; cameraX[0] = 16'h0001;
    cameraY = '0; cameraY[1] = 16'h0001;
    base = hs_cnt;
    start_frame(2, 2);
    check_val("f22_first_dir", 64'(rif.rayDir), 64'h0000_0100_0000_0000);
    repeat (2) tick();
    check_val("f22_third_dir", 64'(rif.rayDir), 64'h0000_0100_0001_0000);
    repeat (2) tick();
    check_val("f22_rays", 64'(hs_cnt - base), 64'd4);
    check_val("f22_busy_unretired", 64'(busy), 64'd1);
    run_to_idle(20, 1'b0);

    // Backpressure on pixel (1,0)
    start_frame(2, 2);
    tick();
    rif.rayReady = 1'b0;
    repeat (5) tick();
    check_val("bp_hold_x", 64'(rif.pixelX), 64'd1);
    check_val("bp_hold_y", 64'(rif.pixelY), 64'd0);
    rif.rayReady = 1'b1;
    tick();
    check_val("bp_next_x", 64'(rif.pixelX), 64'd0);
    check_val("bp_next_y", 64'(rif.pixelY), 64'd1);
    run_to_idle(20, 1'b0);

    // Retire while idle is ignored, then outstanding cap on an 8x1 frame
    rif.rayRetired = 1'b1;
    tick();
    rif.rayRetired = 1'b0;
    random_camera();
    base = hs_cnt;
    start_frame(8, 1);
    repeat (10) tick();
    check_val("cap_rays", 64'(hs_cnt - base), 64'(MAXO));
    check_val("cap_valid", 64'(rif.rayValid), 64'd0);
    rif.rayRetired = 1'b1;
    tick();
    rif.rayRetired = 1'b0;
    repeat (5) tick();
    check_val("cap_one_more", 64'(hs_cnt - base), 64'(MAXO + 1));
    run_to_idle(40, 1'b0);

    // Flush mid-frame after 3 rays
    random_camera();
    base = hs_cnt;
    start_frame(4, 4);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_valid", 64'(rif.rayValid), 64'd0);
    check_val("flush_rays", 64'(hs_cnt - base), 64'd3);
    rif.rayRetired = 1'b1;
    repeat (2) tick();
    check_val("flush_busy", 64'(busy), 64'd1);
    tick();
    rif.rayRetired = 1'b0;
    check_val("flush_ready", 64'(ready), 64'd1);

    // Degenerate start, then starts during EMIT
    base = hs_cnt;
    start_frame(0, 3);
    repeat (3) tick();
    check_val("zero_w_rays", 64'(hs_cnt - base), 64'd0);
    random_camera();
    start_frame(3, 2);
    repeat (4) begin
      start = 1'b1;
      random_camera();
      rif.rayRetired = (m_out > 0);
      tick();
    end
    start = 1'b0;
    run_to_idle(40, 1'b0);
    check_val("overlap_rays", 64'(hs_cnt - base), 64'd6);

    // Wrap of a component, then reset mid-EMIT
    cameraV = '0; cameraV[0] = 16'h0001;
    cameraX = '0; cameraX[0] = 16'h7FFF;
    start_frame(2, 2);
    tick();
    check_val("wrap_x", 64'(rif.rayDir[0]), 64'h8000);
    reset = 1'b0;
    tick();
    check_val("rst_mid_valid", 64'(rif.rayValid), 64'd0);
    check_val("rst_mid_ready", 64'(ready), 64'd1);
    check_val("rst_mid_dir", 64'(rif.rayDir), 64'd0);
    reset = 1'b1;
    tick();

    // Randomized frames with random backpressure, retires, flushes and noise
    for (int f = 0; f < 30; f++) begin
      random_camera();
      start_frame($urandom_range(1, 6), $urandom_range(1, 5));
      run_to_idle(400, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
